// File: rtl/uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// uart_tx_buffered
//
// Buffered 8N1 UART transmitter. Bytes offered by the CPU are queued in a
// small circular FIFO and shifted out LSB first on a registered serial line
// at ClockFreq / BaudRate clocks per bit (integer-truncated).
//
// Handshake: a byte is taken at a rising CLK edge where DataInValid and
// DataInReady are both 1. DataInReady is derived from the registered count,
// so it never depends combinationally on DataInValid; offering a byte while
// DataInReady is 0 is simply ignored (no overwrite, no error). Holding
// DataInValid high queues one byte per ready cycle.
//
// Ports:
//   CLK          in   1               only clock
//   reset        in   1               asynchronous, active low
//   DataIn       in   8               byte to transmit
//   DataInValid  in   1               byte offered this cycle
//   DataInReady  out  1               FIFO has room (count < Depth)
//   SOut         out  1               serial line, registered, idle high
//   TxCount      out  clog2(Depth)+1  bytes queued, excluding the one shifting
//   Busy         out  1               frame in progress or bytes queued
//   o_dbg_state  out  1               FSM state (0 = IDLE, 1 = SEND)
// ---------------------------------------------------------------------------
module uart_tx_buffered #(
    parameter int ClockFreq = 100_000_000,
    parameter int BaudRate  = 115_200,
    parameter int Depth     = 4
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic [7:0]               DataIn,
    input  logic                     DataInValid,
    output logic                     DataInReady,
    output logic                     SOut,
    output logic [$clog2(Depth):0]   TxCount,
    output logic                     Busy,
    output logic                     o_dbg_state
);

    localparam int BitTime = ClockFreq / BaudRate;
    localparam int AW      = $clog2(Depth);
    localparam int CW      = AW + 1;
    localparam int BCW     = (BitTime > 1) ? $clog2(BitTime) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_next;

    logic [7:0]     r_mem [Depth];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;

    logic [9:0]     r_shift;
    logic [3:0]     r_bit;
    logic [BCW-1:0] r_baud;
    logic           r_sout;

    logic           w_ready;
    logic           w_push;
    logic           w_pop;
    logic           w_baud_end;
    logic           w_last_bit;
    logic           w_sout_next;

    assign w_ready    = (r_count < CW'(Depth));
    assign w_push     = DataInValid && w_ready;
    // The head is popped only from IDLE, so the count is at least 1 before
    // any edge that pops.
    assign w_pop      = (r_state == ST_IDLE) && (r_count != '0);
    assign w_baud_end = (r_baud == BCW'(BitTime - 1));
    assign w_last_bit = (r_bit == 4'd9);

    // ---------------- FIFO ----------------
    // Payload storage carries no reset: its contents are only ever read
    // behind a nonzero count.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= DataIn;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_sout  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_sout  <= w_sout_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pop) begin
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                // Stop bit has been held its full BitTime.
                if (w_baud_end && w_last_bit) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // SOut is registered, so its next value is the bit the shifter will
    // present after this edge: 0 on a load, the next shifter bit on a bit
    // boundary, and idle high once the stop bit ends.
    always_comb begin
        w_sout_next = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_sout_next = w_pop ? 1'b0 : 1'b1;
            end
            ST_SEND: begin
                if (w_baud_end) begin
                    w_sout_next = w_last_bit ? 1'b1 : r_shift[1];
                end else begin
                    w_sout_next = r_shift[0];
                end
            end
            default: w_sout_next = 1'b1;
        endcase
    end

    // ---------------- shifter and counters ----------------
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_shift <= '1;
            r_bit   <= '0;
            r_baud  <= '0;
        end else if (w_pop) begin
            r_shift <= {1'b1, r_mem[r_rptr], 1'b0};
            r_bit   <= '0;
            r_baud  <= '0;
        end else if (r_state == ST_SEND) begin
            if (w_baud_end) begin
                r_baud  <= '0;
                r_shift <= {1'b1, r_shift[9:1]};
                r_bit   <= r_bit + 4'd1;
            end else begin
                r_baud  <= r_baud + BCW'(1);
            end
        end
    end

    assign DataInReady = w_ready;
    assign TxCount     = r_count;
    assign SOut        = r_sout;
    assign Busy        = (r_state == ST_SEND) || (r_count != '0);
    assign o_dbg_state = (r_state == ST_SEND);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_buffered
//
// Three transmitters share one clock, reset and data bus:
//   lane 0: BitTime 8, lane 1: BitTime 2, lane 2: ClockFreq 100 / Baud 30 = 3.
// Only the selected lane (cur) is ever driven; the others must stay idle.
// A behavioural model (byte queue plus a frame timer) predicts every output
// of the selected lane each cycle; directed sections pin literal values.
// ---------------------------------------------------------------------------
module tb_uart_tx_buffered;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic reset;
    always #5 CLK = ~CLK;

    logic [7:0] din;
    logic v0, v1, v2;
    logic so0, so1, so2;
    logic rdy0, rdy1, rdy2;
    logic busy0, busy1, busy2;
    logic dbg0, dbg1, dbg2;
    logic [2:0] cnt0, cnt1, cnt2;

    uart_tx_buffered #(.ClockFreq(8), .BaudRate(1), .Depth(4)) u0 (
        .CLK(CLK), .reset(reset), .DataIn(din), .DataInValid(v0),
        .DataInReady(rdy0), .SOut(so0), .TxCount(cnt0), .Busy(busy0),
        .o_dbg_state(dbg0)
    );
    uart_tx_buffered #(.ClockFreq(2), .BaudRate(1), .Depth(4)) u1 (
        .CLK(CLK), .reset(reset), .DataIn(din), .DataInValid(v1),
        .DataInReady(rdy1), .SOut(so1), .TxCount(cnt1), .Busy(busy1),
        .o_dbg_state(dbg1)
    );
    uart_tx_buffered #(.ClockFreq(100), .BaudRate(30), .Depth(4)) u2 (
        .CLK(CLK), .reset(reset), .DataIn(din), .DataInValid(v2),
        .DataInReady(rdy2), .SOut(so2), .TxCount(cnt2), .Busy(busy2),
        .o_dbg_state(dbg2)
    );

    int total = 0;
    int bad   = 0;
    int cur   = 0;
    bit cmp_en = 1'b0;

    function automatic int bt_of(input int l);
        case (l)
            0:       return 8;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic lane_v(input int l);
        case (l)
            0:       return v0;
            1:       return v1;
            default: return v2;
        endcase
    endfunction

    function automatic logic lane_sout(input int l);
        case (l)
            0:       return so0;
            1:       return so1;
            default: return so2;
        endcase
    endfunction

    function automatic logic lane_rdy(input int l);
        case (l)
            0:       return rdy0;
            1:       return rdy1;
            default: return rdy2;
        endcase
    endfunction

    function automatic logic lane_busy(input int l);
        case (l)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic lane_dbg(input int l);
        case (l)
            0:       return dbg0;
            1:       return dbg1;
            default: return dbg2;
        endcase
    endfunction

    function automatic int lane_cnt(input int l);
        case (l)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] exp_q[$];   // bytes accepted and not yet started
    logic [7:0] rx_log[$];  // bytes in the order their frames started
    bit         m_act;
    int         m_cyc;      // cycles since the start bit began
    logic [7:0] m_byte;
    int         m_pre;
    bit         m_acc;

    always @(posedge CLK or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            m_act = 1'b0;
            m_cyc = 0;
        end else begin
            m_pre = exp_q.size();
            m_acc = lane_v(cur) && (m_pre < 4);
            if (m_act) begin
                m_cyc++;
                if (m_cyc == 10 * bt_of(cur)) m_act = 1'b0;
            end else if (m_pre > 0) begin
                m_byte = exp_q.pop_front();
                rx_log.push_back(m_byte);
                m_act = 1'b1;
                m_cyc = 0;
            end
            if (m_acc) exp_q.push_back(din);
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [9:0] c_frame;
    int         c_sout, c_cnt, c_rdy, c_busy, c_dbg;
    int         max_cnt = 0;

    always @(negedge CLK) begin
        if (cmp_en) begin
            for (int l = 0; l < 3; l++) begin
                if (l == cur) begin
                    c_frame = {1'b1, m_byte, 1'b0};
                    c_sout  = m_act ? int'(c_frame[m_cyc / bt_of(cur)]) : 1;
                    c_cnt   = exp_q.size();
                    c_rdy   = (c_cnt < 4) ? 1 : 0;
                    c_busy  = (m_act || c_cnt != 0) ? 1 : 0;
                    c_dbg   = m_act ? 1 : 0;
                    if (lane_cnt(l) > max_cnt) max_cnt = lane_cnt(l);
                end else begin
                    c_sout = 1; c_cnt = 0; c_rdy = 1; c_busy = 0; c_dbg = 0;
                end
                chk($sformatf("sout[%0d]", l),  int'(lane_sout(l)), c_sout);
                chk($sformatf("count[%0d]", l), lane_cnt(l),        c_cnt);
                chk($sformatf("ready[%0d]", l), int'(lane_rdy(l)),  c_rdy);
                chk($sformatf("busy[%0d]", l),  int'(lane_busy(l)), c_busy);
                chk($sformatf("state[%0d]", l), int'(lane_dbg(l)),  c_dbg);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_v(input int l, input logic val);
        case (l)
            0:       v0 = val;
            1:       v1 = val;
            default: v2 = val;
        endcase
    endtask

    // Offers n consecutive bytes first, first+1, ... on n consecutive edges.
    // Called and returns at a falling edge.
    task automatic push_seq(input int l, input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            din = first + 8'(i);
            set_v(l, 1'b1);
            @(negedge CLK);
        end
        set_v(l, 1'b0);
    endtask

    task automatic wait_idle(input int l, input int bound, input string name);
        int n = 0;
        while (lane_busy(l) && n < bound) begin
            @(negedge CLK);
            n++;
        end
        chk(name, int'(lane_busy(l)), 0);
        repeat (2) @(negedge CLK);
    endtask

    task automatic wait_level(input int l, input logic level, input int bound, input string name);
        int n = 0;
        while (lane_sout(l) != level && n < bound) begin
            @(negedge CLK);
            n++;
        end
        chk(name, int'(lane_sout(l)), int'(level));
    endtask

    task automatic run_len(input int l, input logic level, input int bound, output int n);
        n = 0;
        while (lane_sout(l) == level && n < bound) begin
            n++;
            @(negedge CLK);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    logic [9:0] a5_bits;
    int r0, r1, r2, r3, pushed, steps, lows;

    initial begin
        reset = 1'b0;
        din = 8'h00;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        cur = 0;
        repeat (3) @(negedge CLK);
        #2 reset = 1'b1;
        @(negedge CLK);
        cmp_en = 1'b1;

        // Reset values
        chk("rst_sout",  int'(so0),  1);
        chk("rst_ready", int'(rdy0), 1);
        chk("rst_count", int'(cnt0), 0);
        chk("rst_busy",  int'(busy0), 0);

        // Single frame 0xA5, BitTime 8
        a5_bits = 10'b1101001010;
        push_seq(0, 8'hA5, 1);
        chk("t1_count_after_accept", int'(cnt0), 1);
        @(negedge CLK);
        chk("t1_start_bit", int'(so0), 0);
        chk("t1_count_after_pop", int'(cnt0), 0);
        repeat (4) @(negedge CLK);
        for (int b = 0; b < 10; b++) begin
            chk($sformatf("t1_bit%0d", b), int'(so0), int'(a5_bits[b]));
            if (b < 9) repeat (8) @(negedge CLK);
        end
        repeat (4) @(negedge CLK);
        chk("t1_busy_end", int'(busy0), 0);
        chk("t1_idle_line", int'(so0), 1);
        wait_idle(0, 50, "t1_idle_timeout");

        // Fill and overflow: 0x01..0x06 on six consecutive edges
        rx_log.delete();
        push_seq(0, 8'h01, 6);
        chk("t2_count_full", int'(cnt0), 4);
        chk("t2_ready_low", int'(rdy0), 0);
        wait_idle(0, 600, "t2_idle_timeout");
        chk("t2_frames", rx_log.size(), 5);
        for (int i = 0; i < 5 && i < rx_log.size(); i++)
            chk($sformatf("t2_byte%0d", i), int'(rx_log[i]), i + 1);

        // Back-to-back 0x00 then 0xFF: gap of one idle cycle
        push_seq(0, 8'h00, 2);
        wait_level(0, 1'b0, 20, "t3_start_seen");
        run_len(0, 1'b0, 200, r0);
        run_len(0, 1'b1, 200, r1);
        run_len(0, 1'b0, 200, r2);
        chk("t3_low_run_00", r0, 72);
        chk("t3_stop_plus_gap", r1, 9);
        chk("t3_ff_start_bit", r2, 8);
        chk("t3_frame_period", r0 + r1, 81);
        wait_idle(0, 200, "t3_idle_timeout");

        // Pointer wrap-around on lane 1 (BitTime 2)
        cur = 1;
        rx_log.delete();
        max_cnt = 0;
        pushed = 0;
        steps = 0;
        while (pushed < 10 && steps < 500) begin
            if (rdy1) begin
                din = 8'h10 + 8'(pushed);
                v1 = 1'b1;
                pushed++;
            end else begin
                v1 = 1'b0;
            end
            @(negedge CLK);
            steps++;
        end
        v1 = 1'b0;
        chk("t4_all_pushed", pushed, 10);
        wait_idle(1, 400, "t4_idle_timeout");
        chk("t4_frames", rx_log.size(), 10);
        for (int i = 0; i < 10 && i < rx_log.size(); i++)
            chk($sformatf("t4_byte%0d", i), int'(rx_log[i]), 16 + i);
        chk("t4_max_count", max_cnt, 4);

        // Reset mid-frame on lane 0
        cur = 0;
        rx_log.delete();
        push_seq(0, 8'h11, 4);
        chk("t5_queued", int'(cnt0), 3);
        repeat (33) @(negedge CLK);
        chk("t5_data_bit3_before", int'(so0), 0);
        #2 reset = 1'b0;
        #1;
        chk("t5_sout_async", int'(so0), 1);
        chk("t5_count", int'(cnt0), 0);
        chk("t5_ready", int'(rdy0), 1);
        chk("t5_busy", int'(busy0), 0);
        repeat (2) @(negedge CLK);
        #2 reset = 1'b1;
        lows = 0;
        repeat (300) begin
            @(negedge CLK);
            if (!so0) lows++;
        end
        chk("t5_no_frames_after", lows, 0);
        chk("t5_busy_after", int'(busy0), 0);

        // Baud truncation on lane 2: BitTime 3, byte 0x3C
        cur = 2;
        push_seq(2, 8'h3C, 1);
        chk("t6_count_after_accept", int'(cnt2), 1);
        wait_level(2, 1'b0, 10, "t6_start_seen");
        run_len(2, 1'b0, 100, r0);
        run_len(2, 1'b1, 100, r1);
        run_len(2, 1'b0, 100, r2);
        r3 = 0;
        while (busy2 && r3 < 100) begin
            r3++;
            @(negedge CLK);
        end
        chk("t6_low_start_d0_d1", r0, 9);
        chk("t6_high_d2_d5", r1, 12);
        chk("t6_low_d6_d7", r2, 6);
        chk("t6_stop_bit", r3, 3);
        chk("t6_frame_len", r0 + r1 + r2 + r3, 30);
        wait_idle(2, 50, "t6_idle_timeout");

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
